// File: rtl/dataset_swap_ram.sv
`default_nettype none
// =============================================================================
// dataset_swap_ram : double-buffered kernel input RAM refilled from a dataset ROM
// Revision: 1.0
// =============================================================================
module dataset_swap_ram #(
  parameter int    DATA_WIDTH      = 32,
  parameter int    DATA_SIZE       = 1024,
  parameter int    RAM_ADDR_WIDTH  = 10,
  parameter int    DATASET_NUM     = 8,
  parameter int    ROM_ADDR_WIDTH  = 13,
  parameter int    RAM_UPDATE_INV  = 1,
  parameter string ROM_INIT_FILE   = "",
  parameter string RAM_INIT_FILE_0 = "",
  parameter string RAM_INIT_FILE_1 = ""
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  input  logic                          ap_done,
  input  logic                          kram_en,
  input  logic [RAM_ADDR_WIDTH-1:0]     kram_addr,
  output logic [DATA_WIDTH-1:0]         kram_dout,
  output logic                          active_bank,
  output logic                          fill_busy,
  output logic [((DATASET_NUM > 1) ? $clog2(DATASET_NUM) : 1)-1:0] dataset_sel,
  output logic                          overrun
);

  localparam int C_SEL_W     = (DATASET_NUM > 1) ? $clog2(DATASET_NUM) : 1;
  localparam int C_BANK_AW   = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam int C_CNT_W     = C_BANK_AW + 1;
  localparam int C_DC_W      = (RAM_UPDATE_INV > 1) ? $clog2(RAM_UPDATE_INV) : 1;
  localparam int C_ROM_DEPTH = DATA_SIZE * DATASET_NUM;

  typedef enum logic [0:0] {S_FILL = 1'b0, S_READY = 1'b1} state_t;

  logic [DATA_WIDTH-1:0] rom_mem   [0:C_ROM_DEPTH-1];
  logic [DATA_WIDTH-1:0] bank0_mem [0:DATA_SIZE-1];
  logic [DATA_WIDTH-1:0] bank1_mem [0:DATA_SIZE-1];

  state_t               state_q, state_d;
  logic                 active_bank_q, active_bank_d;
  logic [C_SEL_W-1:0]   dataset_sel_q, dataset_sel_d;
  logic [C_SEL_W-1:0]   fill_ds_q, fill_ds_d;
  logic [C_SEL_W-1:0]   next_ds_q, next_ds_d;
  logic [C_DC_W-1:0]    done_cnt_q, done_cnt_d;
  logic                 overrun_q, overrun_d;
  logic [C_CNT_W-1:0]   cnt_q, cnt_d;
  logic                 wr_en_q, wr_en_d;
  logic [C_BANK_AW-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] rom_data_q;
  logic [DATA_WIDTH-1:0] kram_dout_q;

  logic                      w_issue;
  logic [ROM_ADDR_WIDTH-1:0] w_rom_addr;
  logic                      w_rd_in_range;
  logic [C_BANK_AW-1:0]      w_rd_idx;

  assign w_issue    = (state_q == S_FILL) && (cnt_q < C_CNT_W'(DATA_SIZE));
  assign w_rom_addr = ROM_ADDR_WIDTH'(fill_ds_q) * ROM_ADDR_WIDTH'(DATA_SIZE)
                    + ROM_ADDR_WIDTH'(cnt_q);
  assign w_rd_in_range = {1'b0, kram_addr} < (RAM_ADDR_WIDTH + 1)'(DATA_SIZE);
  assign w_rd_idx      = C_BANK_AW'(kram_addr);

  always_comb begin
    state_d       = state_q;
    active_bank_d = active_bank_q;
    dataset_sel_d = dataset_sel_q;
    fill_ds_d     = fill_ds_q;
    next_ds_d     = next_ds_q;
    done_cnt_d    = done_cnt_q;
    overrun_d     = overrun_q;
    cnt_d         = cnt_q;
    wr_en_d       = w_issue;
    wr_addr_d     = C_BANK_AW'(cnt_q);

    if (w_issue) cnt_d = cnt_q + C_CNT_W'(1);
    // The final write and the move to READY share the same clock edge.
    if ((state_q == S_FILL) && wr_en_q && (wr_addr_q == C_BANK_AW'(DATA_SIZE - 1)))
      state_d = S_READY;

    if (ap_done) begin
      if (done_cnt_q == C_DC_W'(RAM_UPDATE_INV - 1)) begin
        done_cnt_d = '0;
        if (state_q == S_READY) begin
          active_bank_d = ~active_bank_q;
          dataset_sel_d = fill_ds_q;
          fill_ds_d     = next_ds_q;
          next_ds_d     = (next_ds_q == C_SEL_W'(DATASET_NUM - 1)) ? '0
                                                                   : next_ds_q + C_SEL_W'(1);
          state_d       = S_FILL;
          cnt_d         = '0;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        done_cnt_d = done_cnt_q + C_DC_W'(1);
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q       <= S_FILL;
      active_bank_q <= 1'b0;
      dataset_sel_q <= '0;
      fill_ds_q     <= C_SEL_W'(1 % DATASET_NUM);
      next_ds_q     <= C_SEL_W'(2 % DATASET_NUM);
      done_cnt_q    <= '0;
      overrun_q     <= 1'b0;
      cnt_q         <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
    end else begin
      state_q       <= state_d;
      active_bank_q <= active_bank_d;
      dataset_sel_q <= dataset_sel_d;
      fill_ds_q     <= fill_ds_d;
      next_ds_q     <= next_ds_d;
      done_cnt_q    <= done_cnt_d;
      overrun_q     <= overrun_d;
      cnt_q         <= cnt_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (w_issue) rom_data_q <= rom_mem[w_rom_addr];
  end

  // Only the shadow bank is written; a reset edge drops any in-flight word.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst && wr_en_q) begin
      if (active_bank_q) bank0_mem[wr_addr_q] <= rom_data_q;
      else               bank1_mem[wr_addr_q] <= rom_data_q;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      kram_dout_q <= '0;
    end else if (kram_en) begin
      if (!w_rd_in_range)     kram_dout_q <= '0;
      else if (active_bank_q) kram_dout_q <= bank1_mem[w_rd_idx];
      else                    kram_dout_q <= bank0_mem[w_rd_idx];
    end
  end

  assign kram_dout   = kram_dout_q;
  assign active_bank = active_bank_q;
  assign fill_busy   = (state_q == S_FILL);
  assign dataset_sel = dataset_sel_q;
  assign overrun     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_dataset_swap_ram.sv
`default_nettype none
// =============================================================================
// tb_dataset_swap_ram : directed bench for dataset_swap_ram (INV=1 and INV=3)
// Revision: 1.0
// =============================================================================
module tb_dataset_swap_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        done1 = 1'b0;
  logic        done3 = 1'b0;
  logic        ken = 1'b0;
  logic [10:0] kaddr = '0;

  logic [31:0] dout1, dout3;
  logic        act1, act3, busy1, busy3, ovr1, ovr3;
  logic [2:0]  sel1, sel3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dataset_swap_ram #(
    .DATA_WIDTH(32), .DATA_SIZE(1024), .RAM_ADDR_WIDTH(11), .DATASET_NUM(8),
    .ROM_ADDR_WIDTH(13), .RAM_UPDATE_INV(1)
  ) dut1 (
    .ap_clk(clk), .ap_rst(rst), .ap_done(done1), .kram_en(ken), .kram_addr(kaddr),
    .kram_dout(dout1), .active_bank(act1), .fill_busy(busy1), .dataset_sel(sel1),
    .overrun(ovr1)
  );

  dataset_swap_ram #(
    .DATA_WIDTH(32), .DATA_SIZE(1024), .RAM_ADDR_WIDTH(11), .DATASET_NUM(8),
    .ROM_ADDR_WIDTH(13), .RAM_UPDATE_INV(3)
  ) dut3 (
    .ap_clk(clk), .ap_rst(rst), .ap_done(done3), .kram_en(ken), .kram_addr(kaddr),
    .kram_dout(dout3), .active_bank(act3), .fill_busy(busy3), .dataset_sel(sel3),
    .overrun(ovr3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse1();
    done1 = 1'b1;
    tick();
    done1 = 1'b0;
  endtask

  task automatic pulse3();
    done3 = 1'b1;
    tick();
    done3 = 1'b0;
  endtask

  task automatic rd(input int a);
    kaddr = 11'(a);
    ken   = 1'b1;
    tick();
    ken   = 1'b0;
  endtask

  task automatic wait_fill(input int which, input string tag);
    int n;
    n = 0;
    while (((which == 1) ? busy1 : busy3) && n < 1100) begin
      tick();
      n++;
    end
    check(tag, 32'((which == 1) ? busy1 : busy3), 32'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 8192; i++) begin
      dut1.rom_mem[i] <= 32'(i);
      dut3.rom_mem[i] <= 32'(i);
    end
    for (int i = 0; i < 1024; i++) begin
      dut1.bank0_mem[i] <= 32'hA000_0000 + 32'(i);
      dut3.bank0_mem[i] <= 32'hA000_0000 + 32'(i);
    end

    // reset state and fill length
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy",   32'(busy1), 32'd1);
    check("rst_active", 32'(act1),  32'd0);
    check("rst_sel",    32'(sel1),  32'd0);
    check("rst_ovr",    32'(ovr1),  32'd0);
    check("rst_dout",   dout1,      32'd0);
    n = 0;
    while (busy1 && n < 2000) begin
      n++;
      tick();
    end
    check("fill_len", 32'(n), 32'd1025);
    check("fill_act", 32'(act1), 32'd0);

    rd(5);
    check("b0_addr5", dout1, 32'hA000_0005);
    kaddr = 11'd9;
    tick();
    check("dout_hold", dout1, 32'hA000_0005);

    // swap every third ap_done
    tick();
    pulse3(); tick();
    check("inv3_p1", 32'(act3), 32'd0);
    pulse3(); tick();
    check("inv3_p2", 32'(act3), 32'd0);
    pulse3();
    check("inv3_p3_act", 32'(act3), 32'd1);
    check("inv3_p3_sel", 32'(sel3), 32'd1);
    wait_fill(3, "inv3_fill");
    pulse3(); tick();
    check("inv3_q1", 32'(act3), 32'd1);
    pulse3(); tick();
    check("inv3_q2", 32'(act3), 32'd1);
    pulse3();
    check("inv3_q3_act", 32'(act3), 32'd0);
    check("inv3_q3_sel", 32'(sel3), 32'd2);
    check("inv3_ovr",    32'(ovr3), 32'd0);

    // nine swaps: dataset_sel 1..7,0,1
    for (int k = 1; k <= 9; k++) begin
      pulse1();
      check("swap_act", 32'(act1), 32'(k % 2));
      check("swap_sel", 32'(sel1), 32'(k % 8));
      if (k == 1) begin
        check("swap_busy", 32'(busy1), 32'd1);
        rd(5);
        check("ds1_addr5", dout1, 32'd1029);
        rd(1024);
        check("oob_addr", dout1, 32'd0);
      end
      rd(7);
      check("ds_addr7", dout1, 32'((k % 8) * 1024 + 7));
      wait_fill(1, "swap_fill");
    end
    check("no_ovr", 32'(ovr1), 32'd0);

    // swap point during fill
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    pulse1();
    check("ovr_act",  32'(act1),  32'd0);
    check("ovr_set",  32'(ovr1),  32'd1);
    check("ovr_busy", 32'(busy1), 32'd1);
    wait_fill(1, "ovr_fill1");
    pulse1();
    check("ovr_sw1_act", 32'(act1), 32'd1);
    check("ovr_sw1_sel", 32'(sel1), 32'd1);
    check("ovr_sticky1", 32'(ovr1), 32'd1);
    wait_fill(1, "ovr_fill2");
    pulse1();
    check("ovr_sw2_act", 32'(act1), 32'd0);
    check("ovr_sw2_sel", 32'(sel1), 32'd2);
    check("ovr_sticky2", 32'(ovr1), 32'd1);

    // reset mid-fill, then ap_done exactly on the final fill write
    repeat (100) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_act",  32'(act1),  32'd0);
    check("mid_rst_sel",  32'(sel1),  32'd0);
    check("mid_rst_ovr",  32'(ovr1),  32'd0);
    check("mid_rst_busy", 32'(busy1), 32'd1);
    repeat (1024) tick();
    check("last_wr_busy", 32'(busy1), 32'd1);
    done1 = 1'b1;
    tick();
    done1 = 1'b0;
    check("last_wr_act",  32'(act1),  32'd0);
    check("last_wr_ovr",  32'(ovr1),  32'd1);
    check("last_wr_busy0", 32'(busy1), 32'd0);
    rd(3);
    check("b0_kept_ds2", dout1, 32'd2051);
    pulse1();
    check("post_rst_act", 32'(act1), 32'd1);
    check("post_rst_sel", 32'(sel1), 32'd1);
    rd(3);
    check("b1_addr3", dout1, 32'd1027);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
